// File: rtl/fetch_seq_defs_pkg.sv
// Shared definitions for the fetch sequencer: state encodings, HALT opcode default,
// instruction opcode field position and small field helpers.
package fetch_seq_defs;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;
  localparam int         OP_MSB          = 31;
  localparam int         OP_LSB          = 26;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

  // Instructions are word aligned, so the two low address bits are always dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Collects big-endian instruction bytes: 24-bit shift register of the bytes seen so far
// plus a 2-bit byte counter; last_byte flags that the incoming byte completes the word.
module fetch_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data_in,
  output logic [23:0] shift_reg,
  output logic [1:0]  byte_cnt,
  output logic        last_byte
);

  logic [23:0] shift_reg_reg;
  logic [1:0]  byte_cnt_reg;

  // The counter wraps 3 -> 0 on its own, so a completed word leaves it ready for the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg_reg <= 24'd0;
      byte_cnt_reg  <= 2'd0;
    end else if (clear) begin
      shift_reg_reg <= 24'd0;
      byte_cnt_reg  <= 2'd0;
    end else if (shift) begin
      shift_reg_reg <= {shift_reg_reg[15:0], data_in};
      byte_cnt_reg  <= byte_cnt_reg + 2'd1;
    end
  end

  assign shift_reg = shift_reg_reg;
  assign byte_cnt  = byte_cnt_reg;
  assign last_byte = (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads one byte per cycle, offers 32-bit words
// over valid/ready, honours redirects and stops on HALT. Optional FETCH_SEQ_RETIRE_CNT_EN adds retire_cnt.
module fetch_sequencer
  import fetch_seq_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_byte,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_word,
  output logic [31:0] ins_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         ins_valid_reg, ins_valid_next;
  logic [31:0]  ins_word_reg, ins_word_next;
  logic [31:0]  ins_pc_reg, ins_pc_next;
  logic         halted_reg, halted_next;

  logic         asm_clear;
  logic         asm_shift;
  logic [23:0]  asm_shift_reg;
  logic [1:0]   asm_byte_cnt;
  logic         asm_last_byte;

  fetch_byte_assembler u_assembler (
    .clk       (CLK),
    .rst       (Reset),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .data_in   (mem_byte),
    .shift_reg (asm_shift_reg),
    .byte_cnt  (asm_byte_cnt),
    .last_byte (asm_last_byte)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      ins_valid_reg <= 1'b0;
      ins_word_reg  <= 32'd0;
      ins_pc_reg    <= RESET_PC;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ins_valid_reg <= ins_valid_next;
      ins_word_reg  <= ins_word_next;
      ins_pc_reg    <= ins_pc_next;
      halted_reg    <= halted_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ins_valid_next = ins_valid_reg;
    ins_word_next  = ins_word_reg;
    ins_pc_next    = ins_pc_reg;
    halted_next    = halted_reg;
    asm_clear      = 1'b0;
    asm_shift      = 1'b0;

    // A redirect overrides everything, including a pending HALT on a coincident accept.
    if (redirect_valid) begin
      pc_next        = align_word(redirect_pc);
      ins_valid_next = 1'b0;
      halted_next    = 1'b0;
      state_next     = FETCH;
      asm_clear      = 1'b1;
    end else begin
      case (state_reg)
        FETCH: begin
          asm_shift = 1'b1;
          if (asm_last_byte) begin
            ins_word_next  = {asm_shift_reg, mem_byte};
            ins_pc_next    = pc_reg;
            ins_valid_next = 1'b1;
            state_next     = HOLD;
          end
        end
        HOLD: begin
          if (ins_ready) begin
            ins_valid_next = 1'b0;
            if (opcode_of(ins_word_reg) == HALT_OP) begin
              state_next  = HALT;
              halted_next = 1'b1;
            end else begin
              pc_next    = pc_reg + 32'd4;
              state_next = FETCH;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  // byte_cnt is zero outside FETCH, so one adder covers every state.
  assign mem_addr  = pc_reg + {30'd0, asm_byte_cnt};
  assign ins_valid = ins_valid_reg;
  assign ins_word  = ins_word_reg;
  assign ins_pc    = ins_pc_reg;
  assign halted    = halted_reg;

`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retire_cnt_reg <= 32'd0;
    end else if (ins_valid_reg && ins_ready) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the byte-wide, big-endian instruction memory.
- Owns the PC and issues one byte address per cycle.
- Assembles 4 bytes into a 32-bit instruction word and offers it downstream over a valid/ready handshake.
- Accepts branch/jump redirects and stops fetching on a HALT opcode. Sits between the PC logic and the decode stage of the CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0
HALT_OP, 6'b111111, opcode (word[31:26]) that stops fetching once accepted

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
mem_addr  out  32  byte address to instruction memory (= pc + byte_cnt)
mem_byte  in  8  byte read combinationally from mem_addr in the same cycle
ins_valid  out  1  ins_word/ins_pc hold a complete instruction
ins_ready  in  1  consumer accepts the instruction this cycle
ins_word  out  32  assembled instruction, big-endian (byte at pc is [31:24])
ins_pc  out  32  address of ins_word
redirect_valid  in  1  load new PC (branch/jump taken)
redirect_pc  in  32  new PC; bits [1:0] forced to 0
halted  out  1  sequencer is in HALT

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, byte_cnt=0, state=FETCH, ins_valid=0, ins_word=0, ins_pc=RESET_PC, halted=0, mem_addr=RESET_PC.
- States: FETCH, HOLD, HALT.
- FETCH:
  - mem_addr = pc + byte_cnt.
  - Each edge: shift_reg <= {shift_reg[23:0], mem_byte}; byte_cnt++.
  - When byte_cnt==3: ins_word <= {shift_reg[23:0], mem_byte}; ins_pc <= pc; ins_valid <= 1; state <= HOLD; byte_cnt <= 0.
  - Latency: ins_valid rises on the 4th edge after entering FETCH.
- HOLD:
  - ins_valid=1; ins_word and ins_pc stable; mem_addr = pc.
  - If ins_ready: ins_valid <= 0. If ins_word[31:26]==HALT_OP, state <= HALT and halted <= 1. Otherwise pc <= pc+4 and state <= FETCH.
  - If !ins_ready: hold indefinitely.
  - Throughput: 5 cycles per instruction with ins_ready tied high.
- HALT: ins_valid=0, halted=1, mem_addr=pc, no fetching.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}; byte_cnt <= 0; ins_valid <= 0; halted <= 0; state <= FETCH.
  - Any partial assembly is discarded.
- Redirect coincident with ins_valid && ins_ready: the instruction counts as accepted, but the redirect target replaces pc+4 and suppresses any HALT transition.
- PC arithmetic is 32-bit and wraps modulo 2^32. mem_addr = pc+byte_cnt also wraps.
- Reset asserted mid-fetch or mid-HOLD: all state returns to reset values immediately (asynchronous); the partial word is lost.
- ins_word/ins_pc change only on capture; they are never updated while ins_valid=1.

Optional Feature:
- Macro: FETCH_SEQ_RETIRE_CNT_EN.
- With it defined:
  - Adds output port retire_cnt [31:0].
  - Reset 0; increments by 1 on every ins_valid && ins_ready cycle, including an accepted HALT and an accept coincident with a redirect.
  - Wraps at 2^32; holds in HALT.
- Without it: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared include/package fetch_seq_defs holds:
  - state encodings (FETCH=2'd0, HOLD=2'd1, HALT=2'd2)
  - HALT_OP default
  - instruction field positions (OP_MSB=31, OP_LSB=26)
- One natural sub-module: fetch_byte_assembler. It holds the 24-bit shift register and 2-bit byte counter, with clear/shift inputs and a last_byte flag. The top keeps the FSM, PC and handshake.

Test Plan:
1. Memory bytes 0x00..0x03 = 20 08 00 05, ins_ready=1 → after reset, ins_valid on 4th edge, ins_word=32'h20080005, ins_pc=0; next offer has ins_pc=4 at cycle 9.
2. ins_ready=0 for 10 cycles with ins_valid=1 → ins_word/ins_pc/mem_addr stable; raise ready → pc advances by 4, next word fetched from addr 4.
3. Redirect to 32'h0000_0043 after 2 bytes fetched → partial word dropped; mem_addr sequence 0x40,0x41,0x42,0x43; ins_pc=0x40.
4. Word FC00_0000 at addr 8, ready=1 → accepted, halted=1 next cycle, ins_valid stays 0; redirect_pc=0 → halted=0 and fetching resumes from 0.
5. Redirect in the same cycle as acceptance of a HALT word → no HALT; fetch continues at the redirect target. With FETCH_SEQ_RETIRE_CNT_EN, retire_cnt increments by 1.
6. Reset asserted between clock edges during HOLD → ins_valid=0, mem_addr=RESET_PC immediately, before the next edge.
